// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Per-requester writeback FIFO; callers gate push with !full_o and pop with !empty_o.
module wb_req_fifo
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  logic    pop_i,
  input  wb_req_t din_i,
  output logic    full_o,
  output logic    empty_o,
  output wb_req_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and MEM writeback.
// Optional REGFILE_WB_BYPASS_EN adds combinational forwarding of the registered write to two read ports.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = regfile_wb_pkg::DATA_W,
  parameter int unsigned ADDR_W     = regfile_wb_pkg::ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        reqValid,
  output logic [1:0]        reqReady,
  input  logic [ADDR_W-1:0] reqAddr0,
  input  logic [DATA_W-1:0] reqData0,
  input  logic [ADDR_W-1:0] reqAddr1,
  input  logic [DATA_W-1:0] reqData1,
  output logic              write,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic [15:0]       commitCount
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rdAddr1,
  input  logic [ADDR_W-1:0] rdAddr2,
  input  logic [DATA_W-1:0] rfData1,
  input  logic [DATA_W-1:0] rfData2,
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2
`endif
);

  import regfile_wb_pkg::wb_req_t;
  import regfile_wb_pkg::REQ_ALU;
  import regfile_wb_pkg::REQ_MEM;
  import regfile_wb_pkg::REG_ZERO;

  localparam int unsigned NREQ = 2;

  wb_req_t           req_in   [NREQ];
  wb_req_t           req_head [NREQ];
  logic [NREQ-1:0]   fifo_full;
  logic [NREQ-1:0]   fifo_empty;
  logic [NREQ-1:0]   push;
  logic [NREQ-1:0]   grant;
  wb_req_t           sel_head;
  logic              pop_any;
  logic              write_d;
  logic              last_mem_q;
  logic              last_mem_d;
  logic              write_q;
  logic [ADDR_W-1:0] wr_reg_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [15:0]       commit_cnt_q;

  assign req_in[REQ_ALU] = '{addr: reqAddr0, data: reqData0};
  assign req_in[REQ_MEM] = '{addr: reqAddr1, data: reqData1};

  // Ready depends only on FIFO occupancy, never on this cycle's grant.
  assign reqReady = ~fifo_full;
  assign push     = reqValid & ~fifo_full;

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_fifo
    wb_req_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[i]),
      .pop_i   (grant[i]),
      .din_i   (req_in[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i]),
      .head_o  (req_head[i])
    );
  end

  // Round-robin grant: on contention, favour whichever requester was not served last.
  always_comb begin
    grant = '0;
    if (!fifo_empty[REQ_ALU] && (fifo_empty[REQ_MEM] || last_mem_q)) begin
      grant[REQ_ALU] = 1'b1;
    end else if (!fifo_empty[REQ_MEM]) begin
      grant[REQ_MEM] = 1'b1;
    end
    pop_any    = |grant;
    sel_head   = grant[REQ_MEM] ? req_head[REQ_MEM] : req_head[REQ_ALU];
    last_mem_d = pop_any ? grant[REQ_MEM] : last_mem_q;
    write_d    = pop_any && (sel_head.addr != REG_ZERO);
  end

  // Writes to $zero still consume a slot and a round-robin turn, but never assert write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_mem_q   <= 1'b1;
      write_q      <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      commit_cnt_q <= '0;
    end else begin
      last_mem_q <= last_mem_d;
      write_q    <= write_d;
      if (pop_any) begin
        wr_reg_q  <= sel_head.addr;
        wr_data_q <= sel_head.data;
      end
      if (write_d) commit_cnt_q <= commit_cnt_q + 16'(1);
    end
  end

  assign write       = write_q;
  assign writeReg    = wr_reg_q;
  assign writeData   = wr_data_q;
  assign commitCount = commit_cnt_q;

`ifdef REGFILE_WB_BYPASS_EN
  assign fwdData1 = (write_q && (wr_reg_q == rdAddr1) && (rdAddr1 != REG_ZERO)) ? wr_data_q : rfData1;
  assign fwdData2 = (write_q && (wr_reg_q == rdAddr2) && (rdAddr2 != REG_ZERO)) ? wr_data_q : rfData2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; the forwarding scenario is built only with REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [1:0]        reqValid = '0;
  logic [1:0]        reqReady;
  logic [ADDR_W-1:0] reqAddr0 = '0;
  logic [DATA_W-1:0] reqData0 = '0;
  logic [ADDR_W-1:0] reqAddr1 = '0;
  logic [DATA_W-1:0] reqData1 = '0;
  logic              write;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [15:0]       commitCount;
`ifdef REGFILE_WB_BYPASS_EN
  logic [ADDR_W-1:0] rdAddr1 = '0;
  logic [ADDR_W-1:0] rdAddr2 = '0;
  logic [DATA_W-1:0] rfData1 = '0;
  logic [DATA_W-1:0] rfData2 = '0;
  logic [DATA_W-1:0] fwdData1;
  logic [DATA_W-1:0] fwdData2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqAddr0    (reqAddr0),
    .reqData0    (reqData0),
    .reqAddr1    (reqAddr1),
    .reqData1    (reqData1),
    .write       (write),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .commitCount (commitCount)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rdAddr1     (rdAddr1),
    .rdAddr2     (rdAddr2),
    .rfData1     (rfData1),
    .rfData2     (rfData2),
    .fwdData1    (fwdData1),
    .fwdData2    (fwdData2)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    reqValid = v;
    reqAddr0 = a0;
    reqData0 = d0;
    reqAddr1 = a1;
    reqData1 = d1;
  endtask

  task automatic do_reset();
    reqValid = 2'b00;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    drive(2'b11, 5'd3, 32'h1234_5678, 5'd4, 32'h9abc_def0);
    repeat (3) step();
    n_checks++;
    if ({write, writeReg, writeData} !== {1'b0, 5'd0, 32'd0}) $display("FAIL reset_outputs: got %h expected %h", {write, writeReg, writeData}, {1'b0, 5'd0, 32'd0});
    else n_pass++;
    n_checks++;
    if (commitCount !== 16'd0) $display("FAIL reset_commit: got %0d expected 0", commitCount);
    else n_pass++;
    reqValid = 2'b00;
    rst_n    = 1'b1;
    step();
    n_checks++;
    if (reqReady !== 2'b11) $display("FAIL reset_ready: got %b expected 11", reqReady);
    else n_pass++;
    n_checks++;
    if (write !== 1'b0) $display("FAIL reset_idle_write: got %b expected 0", write);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    drive(2'b01, 5'd7, 32'hdddd_dddd, 5'd0, 32'd0);
    step();
    reqValid = 2'b00;
    n_checks++;
    if (write !== 1'b0) $display("FAIL single_latency: got write=%b expected 0", write);
    else n_pass++;
    step();
    n_checks++;
    if ({write, writeReg, writeData} !== {1'b1, 5'd7, 32'hdddd_dddd}) $display("FAIL single_write: got %h expected %h", {write, writeReg, writeData}, {1'b1, 5'd7, 32'hdddd_dddd});
    else n_pass++;
    n_checks++;
    if (commitCount !== 16'd1) $display("FAIL single_commit: got %0d expected 1", commitCount);
    else n_pass++;
    step();
    n_checks++;
    if ({write, writeReg, writeData} !== {1'b0, 5'd7, 32'hdddd_dddd}) $display("FAIL single_one_cycle: got %h expected %h", {write, writeReg, writeData}, {1'b0, 5'd7, 32'hdddd_dddd});
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [4:0]  exp_reg  [4] = '{5'd14, 5'd25, 5'd15, 5'd26};
    logic [31:0] exp_data [4] = '{32'hA000_000E, 32'hB000_0019, 32'hA000_000F, 32'hB000_001A};
    logic [1:0]  exp_rdy  [4] = '{2'b01, 2'b11, 2'b11, 2'b11};
    do_reset();
    drive(2'b11, 5'd13, 32'hA000_000D, 5'd24, 32'hB000_0018);
    step();
    n_checks++;
    if ({write, reqReady} !== {1'b0, 2'b11}) $display("FAIL cont_first_edge: got %b expected %b", {write, reqReady}, 3'b011);
    else n_pass++;
    drive(2'b11, 5'd14, 32'hA000_000E, 5'd25, 32'hB000_0019);
    step();
    n_checks++;
    if ({write, writeReg, writeData, reqReady} !== {1'b1, 5'd13, 32'hA000_000D, 2'b01}) $display("FAIL cont_w13: got %h expected %h", {write, writeReg, writeData, reqReady}, {1'b1, 5'd13, 32'hA000_000D, 2'b01});
    else n_pass++;
    drive(2'b11, 5'd15, 32'hA000_000F, 5'd26, 32'hB000_001A);
    step();
    n_checks++;
    if ({write, writeReg, writeData, reqReady} !== {1'b1, 5'd24, 32'hB000_0018, 2'b10}) $display("FAIL cont_w24: got %h expected %h", {write, writeReg, writeData, reqReady}, {1'b1, 5'd24, 32'hB000_0018, 2'b10});
    else n_pass++;
    reqValid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step();
      reqValid = 2'b00;
      n_checks++;
      if ({write, writeReg, writeData, reqReady} !== {1'b1, exp_reg[k], exp_data[k], exp_rdy[k]})
        $display("FAIL cont_w%0d: got %h expected %h", exp_reg[k], {write, writeReg, writeData, reqReady}, {1'b1, exp_reg[k], exp_data[k], exp_rdy[k]});
      else n_pass++;
    end
    step();
    n_checks++;
    if ({write, commitCount} !== {1'b0, 16'd6}) $display("FAIL cont_drain: got %h expected %h", {write, commitCount}, {1'b0, 16'd6});
    else n_pass++;
  endtask

  task automatic test_zero();
    drive(2'b10, 5'd0, 32'd0, 5'd0, 32'h1111_1111);
    step();
    n_checks++;
    if (write !== 1'b0) $display("FAIL zero_push: got write=%b expected 0", write);
    else n_pass++;
    drive(2'b11, 5'd3, 32'hA000_0003, 5'd4, 32'hB000_0004);
    step();
    reqValid = 2'b00;
    n_checks++;
    if ({write, writeReg, writeData, commitCount} !== {1'b0, 5'd0, 32'h1111_1111, 16'd6}) $display("FAIL zero_consume: got %h expected %h", {write, writeReg, writeData, commitCount}, {1'b0, 5'd0, 32'h1111_1111, 16'd6});
    else n_pass++;
    step();
    n_checks++;
    if ({write, writeReg, writeData} !== {1'b1, 5'd3, 32'hA000_0003}) $display("FAIL zero_next_alu: got %h expected %h", {write, writeReg, writeData}, {1'b1, 5'd3, 32'hA000_0003});
    else n_pass++;
    step();
    n_checks++;
    if ({write, writeReg, writeData, commitCount} !== {1'b1, 5'd4, 32'hB000_0004, 16'd8}) $display("FAIL zero_then_mem: got %h expected %h", {write, writeReg, writeData, commitCount}, {1'b1, 5'd4, 32'hB000_0004, 16'd8});
    else n_pass++;
    step();
  endtask

  task automatic test_mid_reset();
    int writes_after;
    do_reset();
    drive(2'b01, 5'd9, 32'h0000_0009, 5'd0, 32'd0);
    step();
    drive(2'b01, 5'd10, 32'h0000_000A, 5'd0, 32'd0);
    step();
    reqValid = 2'b00;
    n_checks++;
    if ({write, writeReg} !== {1'b1, 5'd9}) $display("FAIL midrst_pre: got %h expected %h", {write, writeReg}, {1'b1, 5'd9});
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({write, writeReg, writeData, commitCount} !== {1'b0, 5'd0, 32'd0, 16'd0}) $display("FAIL midrst_async: got %h expected 0", {write, writeReg, writeData, commitCount});
    else n_pass++;
    #1;
    rst_n = 1'b1;
    writes_after = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (write) writes_after++;
    end
    n_checks++;
    if ({writes_after, reqReady} !== {32'd0, 2'b11}) $display("FAIL midrst_discard: got writes=%0d ready=%b expected writes=0 ready=11", writes_after, reqReady);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [ADDR_W+DATA_W-1:0] sb0 [$];
    logic [ADDR_W+DATA_W-1:0] sb1 [$];
    logic [ADDR_W+DATA_W-1:0] exp_e;
    logic acc0, acc1;
    int n_acc0, n_acc1, seen, cyc, stalls;
    n_acc0 = 0; n_acc1 = 0; seen = 0; cyc = 0; stalls = 0;
    do_reset();
    reqAddr0 = 5'($urandom_range(1, 31));
    reqData0 = {1'b0, 31'($urandom)};
    reqValid = 2'b01;
    while ((n_acc0 < 100 || n_acc1 < 100 || sb0.size() != 0 || sb1.size() != 0) && cyc < 3000) begin
      acc0 = reqValid[0] && reqReady[0];
      acc1 = reqValid[1] && reqReady[1];
      if (reqValid[1] && !reqReady[1]) stalls++;
      step();
      cyc++;
      if (acc0) sb0.push_back({reqAddr0, reqData0});
      if (acc1) sb1.push_back({reqAddr1, reqData1});
      if (write) begin
        seen++;
        n_checks++;
        if ((writeData[31] && sb1.size() == 0) || (!writeData[31] && sb0.size() == 0)) begin
          $display("FAIL bp_spurious: got reg=%0d data=%h expected no write", writeReg, writeData);
        end else begin
          exp_e = writeData[31] ? sb1.pop_front() : sb0.pop_front();
          if ({writeReg, writeData} !== exp_e) $display("FAIL bp_order: got %h expected %h", {writeReg, writeData}, exp_e);
          else n_pass++;
        end
      end
      if (acc0) begin
        n_acc0++;
        if (n_acc0 < 100) begin
          reqAddr0 = 5'($urandom_range(1, 31));
          reqData0 = {1'b0, 31'($urandom)};
        end else reqValid[0] = 1'b0;
      end
      if (acc1) begin
        n_acc1++;
        reqValid[1] = 1'b0;
      end
      if (!reqValid[1] && n_acc1 < 100 && $urandom_range(0, 3) != 0) begin
        reqAddr1    = 5'($urandom_range(1, 31));
        reqData1    = {1'b1, 31'($urandom)};
        reqValid[1] = 1'b1;
      end
    end
    reqValid = 2'b00;
    n_checks++;
    if (seen !== 200 || n_acc0 !== 100 || n_acc1 !== 100) $display("FAIL bp_complete: got writes=%0d acc0=%0d acc1=%0d cycles=%0d expected 200/100/100", seen, n_acc0, n_acc1, cyc);
    else n_pass++;
    n_checks++;
    if (commitCount !== 16'd200) $display("FAIL bp_commit: got %0d expected 200", commitCount);
    else n_pass++;
    n_checks++;
    if (stalls == 0) $display("FAIL bp_stall: got %0d stalled cycles expected > 0", stalls);
    else n_pass++;
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    drive(2'b01, 5'd11, 32'h1582_8762, 5'd0, 32'd0);
    step();
    reqValid = 2'b00;
    rdAddr1  = 5'd11;
    rfData1  = 32'h0BAD_0001;
    rdAddr2  = 5'd0;
    rfData2  = 32'h0BAD_0002;
    step();
    n_checks++;
    if ({fwdData1, fwdData2} !== {32'h1582_8762, 32'h0BAD_0002}) $display("FAIL byp_hit: got %h expected %h", {fwdData1, fwdData2}, {32'h1582_8762, 32'h0BAD_0002});
    else n_pass++;
    rdAddr2 = 5'd11;
    rdAddr1 = 5'd12;
    #1;
    n_checks++;
    if ({fwdData1, fwdData2} !== {32'h0BAD_0001, 32'h1582_8762}) $display("FAIL byp_swap: got %h expected %h", {fwdData1, fwdData2}, {32'h0BAD_0001, 32'h1582_8762});
    else n_pass++;
    step();
    rdAddr1 = 5'd11;
    #1;
    n_checks++;
    if ({fwdData1, fwdData2} !== {32'h0BAD_0001, 32'h0BAD_0002}) $display("FAIL byp_nowrite: got %h expected %h", {fwdData1, fwdData2}, {32'h0BAD_0001, 32'h0BAD_0002});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero();
    test_mid_reset();
    test_backpressure();
`ifdef REGFILE_WB_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
